// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a registered register-file write port pulsed on completion.
module muldiv_unit #(
   parameter int unsigned col = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [col-1:0]   rs1_data,
   input  logic [col-1:0]   rs2_data,
   input  logic [4:0]       rd_addr,
   output logic             busy,
   output logic             done,
   output logic             reg_write_en,
   output logic [4:0]       reg_write_dest,
   output logic [col-1:0]   reg_write_data
);

   localparam int unsigned W     = col;
   localparam int unsigned W2    = 2 * col;
   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(col - 1);
   localparam logic [W-1:0]     MIN_INT   = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [W-1:0]      opb_q, opb_d;
   logic [2:0]        f3_q, f3_d;
   logic              negr_q, negr_d;
   logic              nega_q, nega_d;
   logic [4:0]        rd_q, rd_d;
   logic [W-1:0]      res_d;

   // Operand signedness and magnitudes for the incoming request
   logic          a_signed, b_signed, neg_a, neg_b;
   logic [W-1:0]  mag_a, mag_b;

   assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
   assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
   assign neg_a    = a_signed & rs1_data[W-1];
   assign neg_b    = b_signed & rs2_data[W-1];
   assign mag_a    = neg_a ? W'(-rs1_data) : rs1_data;
   assign mag_b    = neg_b ? W'(-rs2_data) : rs2_data;

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
   logic [W:0]    mul_sum, div_tmp, div_diff;
   logic [W2-1:0] mul_step, div_step, step_acc, prod_s;
   logic [W-1:0]  quo, rem, mul_res, div_res, fin_res;

   assign mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opb_q} : (W+1)'(0));
   assign mul_step = {mul_sum, acc_q[W-1:1]};
   assign div_tmp  = {acc_q[W2-1:W], acc_q[W-1]};
   assign div_diff = div_tmp - {1'b0, opb_q};
   assign div_step = div_diff[W] ? {div_tmp[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
   assign step_acc = f3_q[2] ? div_step : mul_step;

   assign prod_s   = negr_q ? W2'(-step_acc) : step_acc;
   assign mul_res  = (f3_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[W2-1:W];
   assign quo      = step_acc[W-1:0];
   assign rem      = step_acc[W2-1:W];
   assign div_res  = f3_q[1] ? (nega_q ? W'(-rem) : rem) : (negr_q ? W'(-quo) : quo);
   assign fin_res  = f3_q[2] ? div_res : mul_res;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      f3_d    = f3_q;
      negr_d  = negr_q;
      nega_d  = nega_q;
      rd_d    = rd_q;
      res_d   = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               f3_d   = funct3;
               rd_d   = rd_addr;
               opb_d  = mag_b;
               acc_d  = {{W{1'b0}}, mag_a};
               negr_d = neg_a ^ neg_b;
               nega_d = neg_a;
               cnt_d  = '0;
               // Divide-by-zero and signed overflow resolve without iterating
               if (funct3[2] && (rs2_data == '0)) begin
                  state_d = DONE;
                  res_d   = funct3[1] ? rs1_data : '1;
               end else if (funct3[2] && !funct3[0] &&
                            (rs1_data == MIN_INT) && (rs2_data == '1)) begin
                  state_d = DONE;
                  res_d   = funct3[1] ? '0 : MIN_INT;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
               res_d   = fin_res;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         acc_q          <= '0;
         opb_q          <= '0;
         f3_q           <= '0;
         negr_q         <= 1'b0;
         nega_q         <= 1'b0;
         rd_q           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         reg_write_en   <= 1'b0;
         reg_write_dest <= '0;
         reg_write_data <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         opb_q          <= opb_d;
         f3_q           <= f3_d;
         negr_q         <= negr_d;
         nega_q         <= nega_d;
         rd_q           <= rd_d;
         busy           <= (state_d != IDLE);
         done           <= (state_d == DONE);
         reg_write_en   <= (state_d == DONE) && (rd_d != '0);
         reg_write_dest <= (state_d == DONE) ? rd_d : '0;
         reg_write_data <= res_d;
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter col, default 32, data width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data  input  32  operand A (dividend / multiplicand).
REQ-007 SHALL have port rs2_data  input  32  operand B (divisor / multiplier).
REQ-008 SHALL have port rd_addr  input  5  destination register.
REQ-009 SHALL have port busy  output  1  high in CALC and DONE; core stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port reg_write_en  output  1  register file write strobe.
REQ-012 SHALL have port reg_write_dest  output  5  register file write address.
REQ-013 SHALL have port reg_write_data  output  32  result to register file.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-015 SHALL latch funct3, rs1_data, rs2_data and rd_addr on the edge that accepts start; later input changes have no effect.
REQ-016 SHALL ignore start while busy=1, including in DONE; no queueing.
REQ-017 SHALL use a 6-bit iteration counter; start accepted at edge k gives CALC in cycles k+1..k+32 and DONE in cycle k+33.
REQ-018 SHALL use radix-2 shift-add multiply on a 64-bit product; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32].
REQ-019 SHALL treat both operands as signed for MULH, rs1 as signed and rs2 as unsigned for MULHSU, and both as unsigned for MULHU.
REQ-020 SHALL use radix-2 restoring division on operand magnitudes; quotient sign = sign(A) XOR sign(B), and remainder sign = sign(A) for DIV and REM.
REQ-021 SHALL, when divisor is 0, go from IDLE to DONE in cycle k+1, returning 0xFFFFFFFF for DIV/DIVU and rs1_data for REM/REMU.
REQ-022 SHALL, for DIV/REM with A=0x80000000 and B=0xFFFFFFFF, go to DONE in cycle k+1, returning 0x80000000 for DIV and 0 for REM.
REQ-023 SHALL, in DONE only, assert done=1, reg_write_dest=latched rd, reg_write_data=result, and reg_write_en=1 unless latched rd=0.
REQ-024 SHALL hold reg_write_en=0 and done=0 in IDLE and CALC; reg_write_data and reg_write_dest SHALL be 0 outside DONE.
REQ-025 SHALL set busy=1 in every CALC and DONE cycle and busy=0 in IDLE.

Reset
REQ-026 SHALL, with reset=1 at an edge, enter IDLE and clear the counter, latched operands and result; busy, done, reg_write_en, reg_write_dest and reg_write_data SHALL be 0.
REQ-027 SHALL, when reset occurs mid-CALC or in DONE, abort the operation with no register write; reset SHALL take priority over a simultaneous start.
REQ-028 SHALL accept a new start in the first cycle after reset is released.

Verification
REQ-029 SHALL pass: MUL A=7, B=0xFFFFFFFD (-3) -> DONE at k+33 with data 0xFFFFFFEB, dest=rd, write_en=1 for exactly one cycle.
REQ-030 SHALL pass: MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-031 SHALL pass: DIV A=-7, B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU with the same operands -> 2.
REQ-032 SHALL pass: DIVU A=5, B=0 -> DONE at k+1 with 0xFFFFFFFF; REM A=0x80000000, B=-1 -> DONE at k+1 with 0.
REQ-033 SHALL pass: start pulsed again at k+5 and k+33 while busy -> ignored, exactly one done; and rd=0 -> done=1 with reg_write_en=0.
REQ-034 SHALL pass: reset asserted at k+10 during DIV -> outputs 0 next cycle, no write ever occurs, and a new MUL started after release completes normally.
